// File: rtl/intersection_pkg.sv
// ----------------------------------------------------------------------------
// intersection_pkg
// Shared types and default timing for the intersection controller.
//   state_t     : phase encoding, also driven out on the phase port
//   lamps_t     : packed lamp vector {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk}
//   lamp_decode : state -> lamp pattern
// Optional feature macro: INTERSECTION_PED_EN (WALK state, used by the top).
// ----------------------------------------------------------------------------
package intersection_pkg;

   typedef enum logic [2:0] {
      AR_NS = 3'd0,
      NS_G  = 3'd1,
      NS_Y  = 3'd2,
      AR_EW = 3'd3,
      EW_G  = 3'd4,
      EW_Y  = 3'd5,
      WALK  = 3'd6
   } state_t;

   localparam int DEF_CNT_W     = 6;
   localparam int DEF_GREEN_T   = 12;
   localparam int DEF_YELLOW_T  = 5;
   localparam int DEF_ALLRED_T  = 2;
   localparam int DEF_MIN_GREEN = 4;
   localparam int DEF_WALK_T    = 6;

   typedef struct packed {
      logic ns_r;
      logic ns_y;
      logic ns_g;
      logic ew_r;
      logic ew_y;
      logic ew_g;
      logic walk;
   } lamps_t;

   // Both reds are the safe default; each G/Y state replaces its own red.
   function automatic lamps_t lamp_decode(input state_t s);
      lamps_t l;
      l      = '0;
      l.ns_r = 1'b1;
      l.ew_r = 1'b1;
      case (s)
         NS_G: begin
            l.ns_r = 1'b0;
            l.ns_g = 1'b1;
         end
         NS_Y: begin
            l.ns_r = 1'b0;
            l.ns_y = 1'b1;
         end
         EW_G: begin
            l.ew_r = 1'b0;
            l.ew_g = 1'b1;
         end
         EW_Y: begin
            l.ew_r = 1'b0;
            l.ew_y = 1'b1;
         end
         WALK:    l.walk = 1'b1;
         default: ;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/intersection_phase_timer.sv
// ----------------------------------------------------------------------------
// phase_timer
// Up-counter measuring time spent in the current phase.
//   clk, rst_n : clock, async active-low reset
//   i_clear    : next edge loads 0 (phase change)
//   i_term     : terminal count for the current phase (duration - 1)
//   o_count    : cycles elapsed in the phase, 0-based
//   o_done     : o_count has reached i_term
// ----------------------------------------------------------------------------
module phase_timer #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic [CNT_W-1:0] i_term,
   output logic [CNT_W-1:0] o_count,
   output logic             o_done
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;
   assign o_done  = (r_count == i_term);

endmodule

// File: rtl/intersection_ctrl.sv
// ----------------------------------------------------------------------------
// intersection_ctrl
// Two-way traffic light controller with request-driven green truncation.
//   clk, rst_n             : clock, async active-low reset
//   req_ns, req_ew         : service requests, sampled every cycle
//   ped_req                : pedestrian request (only with INTERSECTION_PED_EN)
//   ns_r/y/g, ew_r/y/g     : lamp drives
//   walk                   : pedestrian walk lamp
//   phase                  : current state encoding
// Optional feature macro: INTERSECTION_PED_EN adds the WALK phase after EW_Y.
//
// state | meaning
// AR_NS | all red, clearing before NS green
// NS_G  | NS green, truncatable by a pending EW request after MIN_GREEN
// NS_Y  | NS yellow
// AR_EW | all red, clearing before EW green
// EW_G  | EW green, truncatable by a pending NS request after MIN_GREEN
// EW_Y  | EW yellow, goes to WALK if a pedestrian is pending
// WALK  | all red, walk lamp lit (pedestrian build only)
// ----------------------------------------------------------------------------
module intersection_ctrl
   import intersection_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int GREEN_T   = DEF_GREEN_T,
   parameter int YELLOW_T  = DEF_YELLOW_T,
   parameter int ALLRED_T  = DEF_ALLRED_T,
   parameter int MIN_GREEN = DEF_MIN_GREEN,
   parameter int WALK_T    = DEF_WALK_T
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_ns,
   input  logic       req_ew,
   input  logic       ped_req,
   output logic       ns_r,
   output logic       ns_y,
   output logic       ns_g,
   output logic       ew_r,
   output logic       ew_y,
   output logic       ew_g,
   output logic       walk,
   output logic [2:0] phase
);

   localparam int L_MAX = 1 << CNT_W;

   if (MIN_GREEN < 1 || MIN_GREEN > GREEN_T) begin : g_bad_min_green
      $error("intersection_ctrl: MIN_GREEN must be in 1..GREEN_T");
   end
   if (GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1 || WALK_T < 1) begin : g_bad_dur_min
      $error("intersection_ctrl: every duration must be at least 1");
   end
   if (GREEN_T > L_MAX || YELLOW_T > L_MAX || ALLRED_T > L_MAX || WALK_T > L_MAX)
   begin : g_bad_dur_max
      $error("intersection_ctrl: a duration does not fit the CNT_W counter");
   end

   localparam logic [CNT_W-1:0] L_TERM_G   = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] L_TERM_Y   = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] L_TERM_AR  = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] L_TERM_MIN = CNT_W'(MIN_GREEN - 1);
`ifdef INTERSECTION_PED_EN
   localparam logic [CNT_W-1:0] L_TERM_W   = CNT_W'(WALK_T - 1);
`endif

   state_t           r_state;
   state_t           w_state_nxt;
   lamps_t           r_lamps;
   logic             r_pend_ns;
   logic             r_pend_ew;
   logic             w_pend_ns_nxt;
   logic             w_pend_ew_nxt;
   logic [CNT_W-1:0] w_term;
   logic [CNT_W-1:0] w_count;
   logic             w_done;
   logic             w_min_ok;
   logic             w_want_ns;
   logic             w_want_ew;
`ifdef INTERSECTION_PED_EN
   logic             r_pend_ped;
   logic             w_pend_ped_nxt;
`else
   logic             w_unused_ped;
`endif

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_state_nxt != r_state),
      .i_term  (w_term),
      .o_count (w_count),
      .o_done  (w_done)
   );

   always_comb begin
      w_term = L_TERM_AR;
      case (r_state)
         NS_G, EW_G: w_term = L_TERM_G;
         NS_Y, EW_Y: w_term = L_TERM_Y;
`ifdef INTERSECTION_PED_EN
         WALK:       w_term = L_TERM_W;
`endif
         default:    w_term = L_TERM_AR;
      endcase
   end

   // A request arriving this cycle counts as pending, so a request seen at
   // or past the minimum green ends the green on the very next edge.
   assign w_min_ok  = (w_count >= L_TERM_MIN);
   assign w_want_ns = r_pend_ns | req_ns;
   assign w_want_ew = r_pend_ew | req_ew;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         AR_NS: if (w_done) w_state_nxt = NS_G;
         NS_G:  if (w_done || (w_want_ew && w_min_ok)) w_state_nxt = NS_Y;
         NS_Y:  if (w_done) w_state_nxt = AR_EW;
         AR_EW: if (w_done) w_state_nxt = EW_G;
         EW_G:  if (w_done || (w_want_ns && w_min_ok)) w_state_nxt = EW_Y;
`ifdef INTERSECTION_PED_EN
         EW_Y:  if (w_done) w_state_nxt = r_pend_ped ? WALK : AR_NS;
         WALK:  if (w_done) w_state_nxt = AR_NS;
`else
         EW_Y:  if (w_done) w_state_nxt = AR_NS;
`endif
         default: w_state_nxt = AR_NS;
      endcase
   end

   // Entering green clears that direction's flag; a same-cycle request
   // survives the clear. While green, the own-direction request is ignored.
   always_comb begin
      w_pend_ns_nxt = r_pend_ns;
      if (r_state != NS_G) begin
         w_pend_ns_nxt = (w_state_nxt == NS_G) ? req_ns : (r_pend_ns | req_ns);
      end
      w_pend_ew_nxt = r_pend_ew;
      if (r_state != EW_G) begin
         w_pend_ew_nxt = (w_state_nxt == EW_G) ? req_ew : (r_pend_ew | req_ew);
      end
   end

`ifdef INTERSECTION_PED_EN
   always_comb begin
      w_pend_ped_nxt = r_pend_ped | ped_req;
      if (r_state != WALK && w_state_nxt == WALK) begin
         w_pend_ped_nxt = ped_req;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= AR_NS;
         r_lamps    <= lamp_decode(AR_NS);
         r_pend_ns  <= 1'b0;
         r_pend_ew  <= 1'b0;
`ifdef INTERSECTION_PED_EN
         r_pend_ped <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         // Decoding the next state keeps the lamps aligned with r_state.
         r_lamps    <= lamp_decode(w_state_nxt);
         r_pend_ns  <= w_pend_ns_nxt;
         r_pend_ew  <= w_pend_ew_nxt;
`ifdef INTERSECTION_PED_EN
         r_pend_ped <= w_pend_ped_nxt;
`endif
      end
   end

   assign ns_r  = r_lamps.ns_r;
   assign ns_y  = r_lamps.ns_y;
   assign ns_g  = r_lamps.ns_g;
   assign ew_r  = r_lamps.ew_r;
   assign ew_y  = r_lamps.ew_y;
   assign ew_g  = r_lamps.ew_g;
   assign phase = r_state;
`ifdef INTERSECTION_PED_EN
   assign walk  = r_lamps.walk;
`else
   assign walk         = 1'b0;
   assign w_unused_ped = ^{ped_req, r_lamps.walk};
`endif

endmodule

// File: tb/tb_intersection_ctrl.sv
module tb_intersection_ctrl;

   localparam int CNT_W     = 6;
   localparam int GREEN_T   = 12;
   localparam int YELLOW_T  = 5;
   localparam int ALLRED_T  = 2;
   localparam int MIN_GREEN = 4;
   localparam int WALK_T    = 6;
`ifdef INTERSECTION_PED_EN
   localparam bit PED = 1'b1;
`else
   localparam bit PED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_ns = 1'b0;
   logic       req_ew = 1'b0;
   logic       ped_req = 1'b0;
   logic       ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk;
   logic [2:0] phase;
   logic [6:0] w_lamps;

   int total = 0;
   int bad   = 0;

   intersection_ctrl #(
      .CNT_W     (CNT_W),
      .GREEN_T   (GREEN_T),
      .YELLOW_T  (YELLOW_T),
      .ALLRED_T  (ALLRED_T),
      .MIN_GREEN (MIN_GREEN),
      .WALK_T    (WALK_T)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_ns  (req_ns),
      .req_ew  (req_ew),
      .ped_req (ped_req),
      .ns_r    (ns_r),
      .ns_y    (ns_y),
      .ns_g    (ns_g),
      .ew_r    (ew_r),
      .ew_y    (ew_y),
      .ew_g    (ew_g),
      .walk    (walk),
      .phase   (phase)
   );

   always #5 clk = ~clk;

   assign w_lamps = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk};

   // Phase numbers: 0 AR_NS, 1 NS_G, 2 NS_Y, 3 AR_EW, 4 EW_G, 5 EW_Y, 6 WALK
   function automatic int dur_of(input int ph);
      case (ph)
         1, 4:    return GREEN_T;
         2, 5:    return YELLOW_T;
         6:       return WALK_T;
         default: return ALLRED_T;
      endcase
   endfunction

   // {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk}
   function automatic logic [6:0] lamps_of(input int ph);
      case (ph)
         1:       return 7'b0011000;
         2:       return 7'b0101000;
         4:       return 7'b1000010;
         5:       return 7'b1000100;
         6:       return 7'b1001001;
         default: return 7'b1001000;
      endcase
   endfunction

   // Reference model: phase plus cycles already spent in it.
   int m_ph   = 0;
   int m_age  = 0;
   bit m_pns  = 1'b0;
   bit m_pew  = 1'b0;
   bit m_pped = 1'b0;

   always @(posedge clk or negedge rst_n) begin : model
      int nx;
      bit leave;
      if (!rst_n) begin
         m_ph   <= 0;
         m_age  <= 0;
         m_pns  <= 1'b0;
         m_pew  <= 1'b0;
         m_pped <= 1'b0;
      end else begin
         leave = (m_age + 1 >= dur_of(m_ph));
         if (m_ph == 1 && (m_pew || req_ew) && m_age + 1 >= MIN_GREEN) leave = 1'b1;
         if (m_ph == 4 && (m_pns || req_ns) && m_age + 1 >= MIN_GREEN) leave = 1'b1;
         nx = m_ph;
         if (leave) begin
            if (m_ph == 5 && PED && m_pped) nx = 6;
            else if (m_ph >= 5)             nx = 0;
            else                            nx = m_ph + 1;
         end
         m_age <= leave ? 0 : m_age + 1;
         m_ph  <= nx;
         if (m_ph != 1) m_pns <= (nx == 1) ? req_ns : (m_pns | req_ns);
         if (m_ph != 4) m_pew <= (nx == 4) ? req_ew : (m_pew | req_ew);
         if (PED) m_pped <= (nx == 6 && m_ph != 6) ? ped_req : (m_pped | ped_req);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         total++;
         if (phase !== 3'(m_ph) || w_lamps !== lamps_of(m_ph)) begin
            bad++;
            $display("FAIL model_cycle: phase=%0d lamps=%b want phase=%0d lamps=%b at %0t",
                     phase, w_lamps, m_ph, lamps_of(m_ph), $time);
         end
      end
   endtask

   task automatic wait_phase(input int ph, input string name);
      int n;
      n = 0;
      while (int'(phase) != ph && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (int'(phase) != ph) begin
         total++;
         bad++;
         $display("FAIL %s: timeout, phase=%0d want=%0d", name, phase, ph);
      end
   endtask

   // Called at a falling edge; counts cycles the DUT stays in ph.
   task automatic run_len(input int ph, output int len);
      len = 0;
      while (int'(phase) == ph && len < 100) begin
         len++;
         @(negedge clk);
      end
   endtask

   // Counts NS_G cycles, pulsing req_ew during the cycle whose count is 'at'.
   task automatic green_req(input int at, output int len);
      len = 0;
      while (int'(phase) == 1 && len < 100) begin
         req_ew = (len == at);
         len++;
         @(negedge clk);
      end
      req_ew = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      fork
         compare_loop();
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_phase", int'(phase), 0);
      check("rst_lamps", int'(w_lamps), int'(7'b1001000));
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // Free-running cycle, no requests
      run_len(0, len); check("ar_ns_len", len, 2);
      run_len(1, len); check("ns_g_len", len, 12);
      run_len(2, len); check("ns_y_len", len, 5);
      run_len(3, len); check("ar_ew_len", len, 2);
      run_len(4, len); check("ew_g_len", len, 12);
      run_len(5, len); check("ew_y_len", len, 5);
      check("after_ew_y", int'(phase), 0);
      run_len(0, len); check("ar_ns_len2", len, 2);

      // Early request: truncated at minimum green
      wait_phase(1, "t_early");
      green_req(1, len);
      check("trunc_early_len", len, 4);
      check("trunc_early_next", int'(phase), 2);

      // Late request: green ends on the next edge
      wait_phase(1, "t_late");
      green_req(8, len);
      check("trunc_late_len", len, 9);

      // Both requests during AR_EW: EW first, truncated, then full NS green
      wait_phase(3, "t_both");
      req_ns = 1'b1;
      req_ew = 1'b1;
      @(negedge clk);
      req_ns = 1'b0;
      req_ew = 1'b0;
      wait_phase(4, "t_both_ew");
      run_len(4, len); check("both_ew_g_len", len, 4);
      check("both_ew_next", int'(phase), 5);
      wait_phase(1, "t_both_ns");
      run_len(1, len); check("both_ns_g_len", len, 12);

      // Reset mid EW_Y with a pending EW request that must be discarded
      wait_phase(5, "t_rst");
      req_ew = 1'b1;
      @(negedge clk);
      req_ew = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_phase", int'(phase), 0);
      check("midrst_lamps", int'(w_lamps), int'(7'b1001000));
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      run_len(0, len); check("postrst_ar_len", len, 2);
      run_len(1, len); check("postrst_ns_g_len", len, 12);

`ifdef INTERSECTION_PED_EN
      // Pedestrian request during NS_G
      wait_phase(1, "t_ped");
      @(negedge clk);
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      wait_phase(6, "t_walk");
      check("walk_lamps", int'(w_lamps), int'(7'b1001001));
      run_len(6, len); check("walk_len", len, 6);
      check("walk_next", int'(phase), 0);
`endif

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
